prefetch_buffer: RTL and testbench

PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

---
 rtl/riscv_pkg.sv | 19 +
 rtl/pf_fifo.sv | 65 ++++++
 rtl/prefetch_buffer.sv | 104 ++++++++++
 tb/tb_prefetch_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the RISC-V front end.
package riscv_pkg;

  localparam int          DEFAULT_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } pf_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pf_fifo.sv
// In-order {instr, pc} storage for the prefetch buffer, with EMPTY/PARTIAL/FULL control.
module pf_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  pf_entry_t     wdata,
  output pf_entry_t     rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  pf_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  fifo_state_e   state;
  logic          do_push, do_pop;

  // A push into FULL is only accepted when the head leaves in the same cycle.
  assign do_pop    = pop && (state != EMPTY);
  assign do_push   = push && ((state != FULL) || do_pop);
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      if (count_nxt == '0)             state <= EMPTY;
      else if (count_nxt == CW'(DEPTH)) state <= FULL;
      else                              state <= PARTIAL;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (state == FULL);
  assign empty = (state == EMPTY);

  // Credit accounting upstream should make this impossible.
  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (state == FULL) && !pop));

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetcher: credit-limited in-order requests to instr_ram, flush with
// discard of in-flight responses, and a small FIFO of {instr, pc} toward fetch.
module prefetch_buffer
  import riscv_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        req,    // clock, rising edge
  input  logic        reset,  // asynchronous, active low
  input  logic        branch_mispredicted_in,
  input  logic [31:0] pc_in,
  output logic        instr_req_out,
  output logic [31:0] instr_addr_out,
  input  logic        instr_gnt_in,
  input  logic        instr_rvalid_in,
  input  logic [31:0] instr_rdata_in,
  input  logic        fetch_ready_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
);

  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]   fetch_addr, resp_pc;
  logic [CW-1:0] outstanding, discard, fifo_count;
  logic [CW-1:0] out_nxt, disc_nxt, cnt_nxt;
  logic          req_q, req_nxt;
  logic          flush, gnt, rsp, keep, push, pop;
  logic          fifo_full, fifo_empty;
  pf_entry_t     head, wdata;

  assign flush = branch_mispredicted_in;
  assign gnt   = req_q & instr_gnt_in;
  // Responses with nothing in flight (e.g. stale ones across reset) are ignored.
  assign rsp   = instr_rvalid_in & ((outstanding != '0) | (discard != '0));
  assign keep  = rsp & (discard == '0);
  assign push  = keep & ~flush;
  assign pop   = ~fifo_empty & fetch_ready_in & ~flush;
  assign wdata = '{instr: instr_rdata_in, pc: resp_pc};

  always_comb begin
    out_nxt  = outstanding;
    disc_nxt = discard;
    cnt_nxt  = fifo_count;
    if (flush) begin
      // Everything still in flight, including a same-cycle grant, becomes discard.
      out_nxt  = '0;
      disc_nxt = discard + outstanding + CW'(gnt) - CW'(rsp);
      cnt_nxt  = '0;
    end else begin
      out_nxt = outstanding + CW'(gnt) - CW'(keep);
      if (rsp && (discard != '0)) disc_nxt = discard - CW'(1);
      cnt_nxt = fifo_count + CW'(push & (~fifo_full | pop)) - CW'(pop);
    end
  end

  // Registered request: every live response owns a slot, in-flight never exceeds DEPTH.
  assign req_nxt = (({1'b0, cnt_nxt} + {1'b0, out_nxt}) < LIMIT) &&
                   (({1'b0, disc_nxt} + {1'b0, out_nxt}) < LIMIT);

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      fetch_addr  <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      req_q       <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      discard     <= disc_nxt;
      req_q       <= req_nxt;
      if (flush) begin
        fetch_addr <= word_align(pc_in);
        resp_pc    <= word_align(pc_in);
      end else begin
        if (gnt)  fetch_addr <= fetch_addr + 32'd4;
        if (keep) resp_pc    <= resp_pc + 32'd4;
      end
    end
  end

  pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (req),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign instr_req_out   = req_q;
  assign instr_addr_out  = fetch_addr;
  assign instr_valid_out = ~fifo_empty;
  assign instr_out       = fifo_empty ? '0 : head.instr;
  assign pc_out          = fifo_empty ? '0 : head.pc;

endmodule

// File: tb/tb_prefetch_buffer.sv
// Randomized bench for prefetch_buffer against an instruction-stream reference model.
module tb_prefetch_buffer;
  import riscv_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        flush = 1'b0, gnt = 1'b0, rvalid = 1'b0, ready = 1'b0;
  logic [31:0] pc_in = '0, rdata = '0;
  logic        req_o, valid_o;
  logic [31:0] addr_o, instr_o, pc_o;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;

  always #5 clk = ~clk;

  prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .req(clk), .reset(rst_n), .branch_mispredicted_in(flush), .pc_in(pc_in),
    .instr_req_out(req_o), .instr_addr_out(addr_o), .instr_gnt_in(gnt),
    .instr_rvalid_in(rvalid), .instr_rdata_in(rdata), .fetch_ready_in(ready),
    .instr_valid_out(valid_o), .instr_out(instr_o), .pc_out(pc_o)
  );

  prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .req(clk), .reset(rst_n), .branch_mispredicted_in(1'b0), .pc_in(32'h0),
    .instr_req_out(w_req), .instr_addr_out(w_addr), .instr_gnt_in(1'b1),
    .instr_rvalid_in(1'b0), .instr_rdata_in(32'h0), .fetch_ready_in(1'b0),
    .instr_valid_out(w_valid), .instr_out(w_instr), .pc_out(w_pc)
  );

  // Model: memory requests in flight (tagged with flush epoch), fifo occupancy,
  // and the next expected request address / head pc of the instruction stream.
  typedef struct { logic [31:0] addr; int ep; int due; } rsp_t;
  rsp_t        q[$];
  int          epoch = 0, fifo_n = 0, cyc = 0, grants = 0, pops = 0;
  logic [31:0] exp_pc, exp_req;
  int          total = 0, bad = 0;
  int          gnt_pct, rdy_pct, lat_max, flush_pct;
  bit          rsp_hold, rsp_force, flush_now, last_r, last_g;
  logic [31:0] flush_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a[6:2] == 5'd0) ? NOP : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    fifo_n  = 0;
    epoch++;
    exp_pc  = 32'h0;
    exp_req = 32'h0;
  endtask

  task automatic step();
    int kept;
    bit g, r, rd, fl;
    rsp_t e;
    logic [31:0] tgt;
    @(negedge clk);
    cyc++;
    kept = 0;
    foreach (q[i]) if (q[i].ep == epoch) kept++;
    chk("valid", valid_o, 32'(fifo_n > 0));
    chk("req", req_o, 32'((fifo_n + kept < DEPTH) && (q.size() < DEPTH)));
    if (req_o) chk("addr", addr_o, exp_req);
    if (valid_o) begin
      chk("head_pc", pc_o, exp_pc);
      chk("head_instr", instr_o, mem_word(exp_pc));
    end
    fl  = flush_now || ($urandom_range(99) < flush_pct);
    tgt = flush_now ? flush_tgt : $urandom;
    r   = (q.size() > 0) && !rsp_hold && (rsp_force || q[0].due <= cyc);
    g   = ($urandom_range(99) < gnt_pct);
    rd  = ($urandom_range(99) < rdy_pct);
    flush  = fl;
    pc_in  = fl ? tgt : $urandom;
    gnt    = g;
    ready  = rd;
    rvalid = r;
    rdata  = r ? mem_word(q[0].addr) : $urandom;
    last_r = r;
    last_g = g && req_o;
    if (rd && fifo_n > 0 && !fl) begin
      fifo_n--;
      exp_pc += 4;
      pops++;
    end
    if (r) begin
      e = q.pop_front();
      if (!fl && e.ep == epoch) fifo_n++;
    end
    if (g && req_o) begin
      q.push_back('{exp_req, epoch, cyc + 1 + int'($urandom_range(lat_max))});
      grants++;
      exp_req += 4;
    end
    if (fl) begin
      epoch++;
      fifo_n  = 0;
      exp_pc  = {tgt[31:2], 2'b00};
      exp_req = {tgt[31:2], 2'b00};
    end
  endtask

  initial begin
    int first_g, w_n, g0, n;
    logic [31:0] w_exp;
    gnt_pct = 100; rdy_pct = 0; lat_max = 0; flush_pct = 0;
    rsp_hold = 0; rsp_force = 0; flush_now = 0; flush_tgt = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", req_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_pc", pc_o, 0);
    rst_n = 1'b1;

    // Always-grant, 1-cycle latency, no consumption: fill and stop.
    first_g = -1; w_n = 0; w_exp = 32'hFFFF_FFF8;
    for (int i = 0; i < 12; i++) begin
      step();
      if (first_g < 0 && grants > 0) first_g = cyc;
      if (first_g >= 0 && cyc == first_g + 2) begin
        chk("first_head_valid", valid_o, 1);
        chk("first_head_pc", pc_o, 32'h0);
      end
      if (w_req && w_n < 3) begin
        chk("wrap_addr", w_addr, w_exp);
        w_exp += 4;
        w_n++;
      end
    end
    chk("wrap_count", w_n, 3);
    chk("fill_grants", grants, 4);
    chk("fill_req_off", req_o, 0);
    chk("fill_valid", valid_o, 1);

    // Drain, then leave exactly two requests outstanding and flush to 0x102.
    rdy_pct = 100; gnt_pct = 0; rsp_hold = 1;
    repeat (6) step();
    chk("drained", valid_o, 0);
    g0 = grants; gnt_pct = 100; n = 0;
    while (grants < g0 + 2 && n < 10) begin step(); n++; end
    gnt_pct = 0;
    chk("two_outstanding", grants - g0, 2);
    flush_tgt = 32'h0000_0102; flush_now = 1;
    step();
    flush_now = 0; rsp_hold = 0; gnt_pct = 100; rdy_pct = 0;
    step();
    chk("flush_addr", addr_o, 32'h0000_0100);
    n = 0;
    while (!valid_o && n < 15) begin step(); n++; end
    chk("flush_head_valid", valid_o, 1);
    chk("flush_head_pc", pc_o, 32'h0000_0100);

    // Flush coinciding with both a response and a grant.
    rdy_pct = 100;
    repeat (6) step();
    flush_now = 1; rsp_force = 1; flush_tgt = $urandom;
    step();
    flush_now = 0; rsp_force = 0;
    chk("flush_rsp_gnt", {30'd0, last_r, last_g}, 32'd3);
    step();
    chk("valid_after_flush", valid_o, 0);

    // Randomized traffic.
    for (int blk = 0; blk < 25; blk++) begin
      gnt_pct   = $urandom_range(100, 30);
      rdy_pct   = $urandom_range(100, 20);
      lat_max   = $urandom_range(3, 0);
      flush_pct = $urandom_range(5, 0);
      repeat (100) step();
    end
    flush_pct = 0;
    chk("progress", 32'(pops > 200), 1);

    // Asynchronous reset with three requests outstanding.
    rsp_hold = 1; gnt_pct = 100; rdy_pct = 100; n = 0;
    while (q.size() < 3 && n < 20) begin step(); n++; end
    chk("three_outstanding", q.size(), 3);
    #2 rst_n = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; flush = 1'b0; gnt = 1'b0;
    #1;
    chk("arst_req", req_o, 0);
    chk("arst_valid", valid_o, 0);
    chk("arst_instr", instr_o, 0);
    chk("arst_pc", pc_o, 0);
    model_reset();
    repeat (3) @(negedge clk);
    chk("arst_hold_valid", valid_o, 0);
    rvalid = 1'b0; rsp_hold = 0; lat_max = 1; rdy_pct = 0;
    rst_n = 1'b1;
    n = 0;
    while (!valid_o && n < 20) begin step(); n++; end
    chk("post_rst_valid", valid_o, 1);
    chk("post_rst_pc", pc_o, 32'h0);
    rdy_pct = 70;
    repeat (30) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
